iter_alu: RTL



---
 rtl/iter_alu_if.sv | 22 ++
 rtl/iter_alu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/iter_alu_if.sv
// Operand/result bundle between the EX-stage control and the iterative ALU.
// The master drives requests and operands; the slave returns results and status.
interface iter_alu_if #(parameter int WIDTH = 32);
   logic             start;
   logic [3:0]       operation;
   logic [1:0]       sign;
   logic [2:0]       cmpsignal;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] outHI;
   logic [WIDTH-1:0] outLO;
   logic [3:0]       carryFlag;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (output start, operation, sign, cmpsignal, A, B,
                   input  Y, outHI, outLO, carryFlag, busy, done, div_zero);
   modport slave  (input  start, operation, sign, cmpsignal, A, B,
                   output Y, outHI, outLO, carryFlag, busy, done, div_zero);
endinterface

// File: rtl/iter_alu.sv
// Clocked ALU: single-cycle ops return a registered Y; mul/div iterate over
// magnitudes for WIDTH cycles and apply signs in a final fix-up cycle.
//   state  | meaning
//   S_IDLE | accepting requests, single-cycle ops complete here
//   S_MUL  | shift-add multiply, one multiplier bit per cycle
//   S_DIV  | restoring divide, one quotient bit per cycle
//   S_FIX  | sign correction, HI/LO written, done pulsed
module iter_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic        clk,
   input logic        reset,
   iter_alu_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_MUL = 4'h2;
   localparam logic [3:0] OP_DIV = 4'h3;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   y_q, y_d, hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]   wh_q, wh_d, wl_q, wl_d, opnd_q, opnd_d;
   logic [3:0]         flags_q, flags_d;
   logic               done_q, done_d, dz_q, dz_d;
   logic               is_div_q, is_div_d, neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d, div0_q, div0_d;

   logic [WIDTH-1:0]   b_eff, alu_y, a_mag, b_mag, m_add, d_sub, q_fix, r_fix;
   logic [WIDTH:0]     sum_ext, m_sum, d_shift;
   logic [2*WIDTH-1:0] prod_neg;
   logic               add_v, cmp_eq, cmp_lt, cmp_res, d_ge;

   always_comb begin
      b_eff   = bus.sign[0] ? ~bus.B : bus.B;
      sum_ext = {1'b0, bus.A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.sign[0]};
      // Overflow in A + b_eff covers subtract too, since b_eff is already inverted.
      add_v   = bus.sign[1] & (bus.A[WIDTH-1] == b_eff[WIDTH-1])
                & (sum_ext[WIDTH-1] != bus.A[WIDTH-1]);
      cmp_eq  = (bus.A == bus.B);
      cmp_lt  = bus.sign[1] ? ($signed(bus.A) < $signed(bus.B)) : (bus.A < bus.B);
      case (bus.cmpsignal)
         3'b000:  cmp_res = cmp_eq;
         3'b001:  cmp_res = ~cmp_eq;
         3'b010:  cmp_res = cmp_lt;
         3'b011:  cmp_res = cmp_lt | cmp_eq;
         3'b100:  cmp_res = ~(cmp_lt | cmp_eq);
         3'b101:  cmp_res = ~cmp_lt;
         default: cmp_res = 1'b0;
      endcase
      case (bus.operation)
         4'h0:    alu_y = bus.B;
         4'h1:    alu_y = sum_ext[WIDTH-1:0];
         4'h4:    alu_y = bus.A & bus.B;
         4'h5:    alu_y = bus.A | bus.B;
         4'h6:    alu_y = ~(bus.A | bus.B);
         4'h7:    alu_y = bus.B >> bus.A[SHW-1:0];
         4'h8:    alu_y = bus.B << bus.A[SHW-1:0];
         4'h9:    alu_y = $unsigned($signed(bus.B) >>> bus.A[SHW-1:0]);
         4'hA:    alu_y = {bus.A[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         4'hB:    alu_y = bus.B + WIDTH'(4);
         4'hC:    alu_y = bus.A ^ bus.B;
         4'hD:    alu_y = {{(WIDTH-1){1'b0}}, cmp_res};
         default: alu_y = y_q;
      endcase
      a_mag = (bus.sign[1] && bus.A[WIDTH-1]) ? -bus.A : bus.A;
      b_mag = (bus.sign[1] && bus.B[WIDTH-1]) ? -bus.B : bus.B;
   end

   always_comb begin
      m_add    = wl_q[0] ? opnd_q : '0;
      m_sum    = {1'b0, wh_q} + {1'b0, m_add};
      d_shift  = {wh_q, wl_q[WIDTH-1]};
      d_ge     = (d_shift >= {1'b0, opnd_q});
      d_sub    = d_shift[WIDTH-1:0] - opnd_q;
      prod_neg = -{wh_q, wl_q};
      q_fix    = neg_res_q ? -wl_q : wl_q;
      r_fix    = neg_rem_q ? -wh_q : wh_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      y_d       = y_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      wh_d      = wh_q;
      wl_d      = wl_q;
      opnd_d    = opnd_q;
      flags_d   = flags_q;
      done_d    = 1'b0;
      dz_d      = dz_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               dz_d = 1'b0;
               if (bus.operation == OP_MUL || bus.operation == OP_DIV) begin
                  state_d   = (bus.operation == OP_MUL) ? S_MUL : S_DIV;
                  is_div_d  = (bus.operation == OP_DIV);
                  cnt_d     = CW'(WIDTH);
                  wh_d      = '0;
                  wl_d      = a_mag;
                  opnd_d    = b_mag;
                  neg_res_d = bus.sign[1] & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                  neg_rem_d = bus.sign[1] & bus.A[WIDTH-1];
                  div0_d    = (bus.B == '0);
               end else begin
                  y_d    = alu_y;
                  done_d = 1'b1;
                  if (bus.operation == OP_ADD)
                     flags_d = {sum_ext[WIDTH], (sum_ext[WIDTH-1:0] == '0),
                                sum_ext[WIDTH-1], add_v};
               end
            end
         end
         S_MUL: begin
            wh_d  = m_sum[WIDTH:1];
            wl_d  = {m_sum[0], wl_q[WIDTH-1:1]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_DIV: begin
            wh_d  = d_ge ? d_sub : d_shift[WIDTH-1:0];
            wl_d  = {wl_q[WIDTH-2:0], d_ge};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         default: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (is_div_q) begin
               // With a zero divisor the remainder path reproduces |A|, so the
               // dividend-sign fix-up hands back A unchanged.
               hi_d = r_fix;
               lo_d = div0_q ? '1 : q_fix;
               dz_d = div0_q;
            end else begin
               {hi_d, lo_d} = neg_res_q ? prod_neg : {wh_q, wl_q};
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         y_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         wh_q      <= '0;
         wl_q      <= '0;
         opnd_q    <= '0;
         flags_q   <= '0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         y_q       <= y_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         wh_q      <= wh_d;
         wl_q      <= wl_d;
         opnd_q    <= opnd_d;
         flags_q   <= flags_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
      end
   end

   assign bus.Y         = y_q;
   assign bus.outHI     = hi_q;
   assign bus.outLO     = lo_q;
   assign bus.carryFlag = flags_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = done_q;
   assign bus.div_zero  = dz_q;
endmodule
